// File: rtl/mips_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
// Holds the arbiter state encoding and the default AW/DW constants.
package mips_arb_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mux2_w.sv
// Width-parameterised 2:1 mux; purely combinational, zero latency.
// No flow control: the output follows i_sel and the selected input.
module mux2_w #(
  parameter int DW = 32
) (
  input  logic          i_sel,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester single memory port arbiter: grant one cycle after req, done one cycle after mem_ready.
// Holds the grant while mem_ready is low; ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module mem_port_arbiter
  import mips_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          we0,
  input  logic          we1,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_valid,
  output logic          sel
);

  arb_state_t    r_state;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_done0;
  logic          r_done1;
  logic          r_valid;
  logic          r_sel;
  logic [DW-1:0] r_rdata;
  logic          w_win;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last;
  logic w_tie;

  // On a tie the requester not granted last wins; r_last resets to 1 so 0 wins first.
  assign w_tie = req0 & req1;
  assign w_win = w_tie ? ~r_last : req1;
`else
  assign w_win = ~req0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_valid <= 1'b0;
      r_sel   <= 1'b0;
      r_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last  <= 1'b1;
`endif
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req0 | req1) begin
            r_state <= w_win ? GRANT1 : GRANT0;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_valid <= 1'b1;
            r_sel   <= w_win;
`ifdef ARB_ROUND_ROBIN_EN
            r_last  <= w_win;
`endif
          end
        end
        GRANT0, GRANT1: begin
          // Grant is held until memory completes, even if req drops.
          if (mem_ready) begin
            r_state <= IDLE;
            r_done0 <= (r_state == GRANT0);
            r_done1 <= (r_state == GRANT1);
            r_rdata <= mem_rdata;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_valid <= 1'b0;
            r_sel   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_valid <= 1'b0;
          r_sel   <= 1'b0;
        end
      endcase
    end
  end

  mux2_w #(.DW(AW)) u_addr_mux (
    .i_sel (r_sel),
    .i_a   (addr0),
    .i_b   (addr1),
    .o_y   (mem_addr)
  );

  mux2_w #(.DW(DW)) u_wdata_mux (
    .i_sel (r_sel),
    .i_a   (wdata0),
    .i_b   (wdata1),
    .o_y   (mem_wdata)
  );

  assign mem_we    = r_valid & (r_sel ? we1 : we0);
  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign rdata     = r_rdata;
  assign mem_valid = r_valid;
  assign sel       = r_sel;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Tie-order expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        we0, we1;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        mem_we, mem_valid, sel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .we0       (we0),
    .we1       (we1),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_valid (mem_valid),
    .sel       (sel)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_w;
    rst_n = 1'b0; req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
    wdata0 = 0; wdata1 = 0; we0 = 0; we1 = 0; mem_ready = 0; mem_rdata = 0;
    step(); step();
    check_eq("rst_gnt0", {31'b0, gnt0}, 0);
    check_eq("rst_gnt1", {31'b0, gnt1}, 0);
    check_eq("rst_valid", {31'b0, mem_valid}, 0);
    check_eq("rst_sel", {31'b0, sel}, 0);
    check_eq("rst_done", {30'b0, done1, done0}, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_we", {31'b0, mem_we}, 0);
    rst_n = 1'b1;
    step();

    // Single request from requester 0.
    req0 = 1; addr0 = 5;
    #1 check_eq("lat_gnt0_before", {31'b0, gnt0}, 0);
    step();
    check_eq("single_gnt0", {31'b0, gnt0}, 1);
    check_eq("single_valid", {31'b0, mem_valid}, 1);
    check_eq("single_addr", mem_addr, 5);
    check_eq("single_sel", {31'b0, sel}, 0);
    req0 = 0; mem_ready = 1; mem_rdata = 17;
    step();
    check_eq("single_done0", {31'b0, done0}, 1);
    check_eq("single_rdata", rdata, 17);
    check_eq("single_gnt_drop", {30'b0, gnt1, gnt0}, 0);
    mem_ready = 0; mem_rdata = 0;
    step();
    check_eq("single_done_pulse", {31'b0, done0}, 0);
    check_eq("single_rdata_hold", rdata, 17);

    // Stall with req drop on requester 1.
    req1 = 1; we1 = 1; addr1 = 15; wdata1 = 99;
    step();
    check_eq("stall_gnt1", {31'b0, gnt1}, 1);
    check_eq("stall_sel", {31'b0, sel}, 1);
    check_eq("stall_wdata", mem_wdata, 99);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) req1 = 0;
      check_eq("stall_addr", mem_addr, 15);
      check_eq("stall_we", {31'b0, mem_we}, 1);
      check_eq("stall_hold_gnt1", {31'b0, gnt1}, 1);
      check_eq("stall_no_done", {31'b0, done1}, 0);
      step();
    end
    mem_ready = 1; mem_rdata = 33;
    step();
    check_eq("stall_done1", {31'b0, done1}, 1);
    check_eq("stall_rdata", rdata, 33);
    check_eq("stall_we_idle", {31'b0, mem_we}, 0);
    mem_ready = 0; we1 = 0;
    step();

    // Reset in the middle of a requester-1 access.
    req1 = 1; addr1 = 7;
    step();
    check_eq("mid_gnt1", {31'b0, gnt1}, 1);
    req1 = 0;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_gnt1", {31'b0, gnt1}, 0);
    check_eq("mid_rst_valid", {31'b0, mem_valid}, 0);
    check_eq("mid_rst_sel", {31'b0, sel}, 0);
    check_eq("mid_rst_rdata", rdata, 0);
    mem_ready = 1;
    step();
    check_eq("mid_rst_no_done1", {31'b0, done1}, 0);
    rst_n = 1'b1;
    mem_ready = 0;
    step();
    check_eq("post_rst_idle", {30'b0, gnt1, gnt0}, 0);

    // Held tie with mem_ready always high.
    req0 = 1; req1 = 1; mem_ready = 1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_w = k[0];
`else
      exp_w = 1'b0;
`endif
      step();
      check_eq("tie_gnt0", {31'b0, gnt0}, {31'b0, ~exp_w});
      check_eq("tie_gnt1", {31'b0, gnt1}, {31'b0, exp_w});
      check_eq("tie_sel", {31'b0, sel}, {31'b0, exp_w});
      step();
      check_eq("tie_idle_gap", {30'b0, gnt1, gnt0}, 0);
      check_eq("tie_done", {30'b0, done1, done0}, exp_w ? 32'd2 : 32'd1);
    end
    req0 = 0; req1 = 0; mem_ready = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0/req1  input  1  access request from requester 0 (fetch) / 1 (data).
REQ-006 SHALL have ports addr0/addr1  input  AW  requester address; wdata0/wdata1  input  DW; we0/we1  input  1  write enable.
REQ-007 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-008 SHALL have port mem_rdata  input  DW  memory read data.
REQ-009 SHALL have ports gnt0/gnt1  output  1  requester owns the port.
REQ-010 SHALL have ports done0/done1  output  1  one-cycle access-complete pulse.
REQ-011 SHALL have port rdata  output  DW  mem_rdata, registered on completion.
REQ-012 SHALL have ports mem_addr  output  AW; mem_wdata  output  DW; mem_we  output  1; mem_valid  output  1; sel  output  1  (0 = requester 0, 1 = requester 1).

Function
REQ-013 SHALL implement an FSM with states IDLE, GRANT0 and GRANT1.
REQ-014 IDLE: if any req is high, SHALL enter GRANTx on the next edge; with no req, SHALL stay in IDLE.
REQ-015 Request-to-grant latency SHALL be exactly one cycle: req sampled in IDLE, gnt/mem_valid high the following cycle.
REQ-016 In GRANTx, gntx and mem_valid SHALL be 1, and sel SHALL equal x (registered, state-decoded).
REQ-017 mem_addr/mem_wdata/mem_we SHALL be the sel-selected requester's inputs (combinational mux); when mem_valid=0, mem_we SHALL be 0.
REQ-018 In GRANTx with mem_ready=1: SHALL pulse donex for one cycle, load rdata from mem_rdata, and return to IDLE on that edge (gnt drops the same edge).
REQ-019 In GRANTx with mem_ready=0: SHALL hold the grant indefinitely; no preemption.
REQ-020 req dropping during GRANTx SHALL NOT abort the access: the access completes and done still pulses.
REQ-021 On simultaneous req0 and req1 in IDLE, the winner SHALL follow REQ-026/REQ-027.
REQ-022 Minimum spacing between back-to-back grants SHALL be one IDLE cycle; sustained throughput SHALL be at most one access per 2 cycles.

Reset
REQ-023 When rst_n=0, SHALL immediately force: state IDLE, gnt0=gnt1=0, done0=done1=0, mem_valid=0, sel=0, rdata=0, last-grant register=1.
REQ-024 Reset mid-access SHALL abandon the access with no done pulse; after release, the FSM starts from IDLE.

Configuration
REQ-025 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-026 With ARB_ROUND_ROBIN_EN defined: on a tie, SHALL grant the requester not granted last; the last-grant register updates on entry to GRANTx; after reset, requester 0 wins the first tie.
REQ-027 With ARB_ROUND_ROBIN_EN undefined: SHALL use fixed priority, requester 0 always winning a tie; the last-grant register SHALL be absent.

Structure
REQ-028 Package mips_arb_pkg SHALL hold the state enumeration and the default AW/DW constants.
REQ-029 Submodule mux2_w (DW-parameterised 2:1 mux) SHALL be instantiated for address and write data; the FSM SHALL stay in mem_port_arbiter.

Verification
REQ-030 Reset: rst_n=0 mid-GRANT1 -> gnt1=0, mem_valid=0 and sel=0 immediately, with no done1 pulse.
REQ-031 Single request: req0=1, addr0=5 -> the next cycle gnt0=1, mem_addr=5, sel=0; mem_ready=1 with mem_rdata=17 -> done0 pulses and rdata=17.
REQ-032 Tie (round robin): req0=req1=1 held, mem_ready=1 always -> grant order 0,1,0,1 with one IDLE cycle between each.
REQ-033 Tie (fixed): macro undefined, req0=req1=1 held -> gnt0 on every grant; gnt1 never asserted.
REQ-034 Stall and drop: gnt1 active with we1=1 and addr1=15, mem_ready=0 for 4 cycles, req1 dropped in cycle 2 -> mem_addr=15 and mem_we=1 held throughout; done1 pulses when mem_ready rises.
